// File: rtl/gsm_buf_alloc.sv
// gsm_buf_alloc: free-cell address manager for the grouped-share-memory
// central RAM (clk_320M domain). Freed cell addresses are kept in a FIFO
// held in a DEPTH x AWIDTH simple dual-port RAM. The RAM feeds a one-entry
// prefetch register (skid), which feeds a show-ahead head register.
// After reset or clr the list self-initialises with addresses 0..DEPTH-1.
// Optional build macro GSM_ALLOC_BYPASS_EN: a free into an empty list
// (or one arriving while the last entry is popped) loads the head directly.
module gsm_buf_alloc #(
  parameter int AWIDTH = 9,
  parameter int CWIDTH = 10
) (
  input  logic              clk_320M,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              i_alloc_req,
  output logic              o_alloc_valid,
  output logic [AWIDTH-1:0] o_alloc_addr,
  input  logic              i_free_en,
  input  logic [AWIDTH-1:0] i_free_addr,
  output logic              o_init_done,
  output logic [CWIDTH-1:0] o_free_count,
  output logic              o_err_overflow
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [CWIDTH-1:0] DEPTH_C = CWIDTH'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {ST_INIT, ST_FILL, ST_READY} state_t;

  state_t state_reg, state_next;

  logic [AWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] rd_data_reg;
  logic [AWIDTH-1:0] head_reg;
  logic [AWIDTH-1:0] wr_ptr_reg;
  logic [AWIDTH-1:0] rd_ptr_reg;
  logic              head_vld_reg;
  logic              skid_vld_reg;
  logic              init_done_reg;
  logic              err_reg;
  logic [CWIDTH-1:0] count_reg;

  logic [CWIDTH-1:0] ram_cnt;
  logic              pop;
  logic              skid_take;
  logic              rd_en;
  logic              wr_en;
  logic              ram_we;
  logic              bypass;
  logic              free_acc;
  logic              free_drop;
  logic              init_wr;
  logic [AWIDTH-1:0] wr_data;

  // Next-state and datapath control; the count covers RAM + skid + head,
  // so the RAM occupancy is derived from it rather than stored twice.
  always_comb begin
    state_next = state_reg;
    init_wr    = 1'b0;
    wr_en      = 1'b0;
    wr_data    = i_free_addr;
    rd_en      = 1'b0;
    bypass     = 1'b0;
    free_acc   = 1'b0;
    free_drop  = 1'b0;
    ram_cnt    = count_reg - CWIDTH'(skid_vld_reg) - CWIDTH'(head_vld_reg);
    pop        = (state_reg == ST_READY) && i_alloc_req && head_vld_reg;
    skid_take  = skid_vld_reg && (!head_vld_reg || pop);
    case (state_reg)
      ST_INIT: begin
        // Address k written to location k; frees here are an error.
        init_wr   = 1'b1;
        wr_en     = 1'b1;
        wr_data   = wr_ptr_reg;
        free_drop = i_free_en;
        if (wr_ptr_reg == LAST_ADDR) begin
          state_next = ST_FILL;
        end
      end
      ST_FILL, ST_READY: begin
        // Keep the skid full whenever the RAM holds entries; a read is never
        // issued in the same cycle as a write to the same location because
        // that needs an empty (no read) or full (no accepted write) RAM.
        rd_en = (ram_cnt != '0) && (!skid_vld_reg || skid_take);
`ifdef GSM_ALLOC_BYPASS_EN
        bypass = i_free_en && (ram_cnt == '0) && !skid_vld_reg &&
                 (!head_vld_reg || pop);
`else
        bypass = 1'b0;
`endif
        free_acc  = i_free_en && ((count_reg != DEPTH_C) || pop);
        free_drop = i_free_en && !free_acc;
        wr_en     = free_acc && !bypass;
        if (state_reg == ST_FILL) begin
          state_next = ST_READY;
        end
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  assign ram_we = wr_en && !clr;

  // Free-list RAM: one write port, registered read into the skid register.
  always_ff @(posedge clk_320M) begin
    if (ram_we) begin
      mem[wr_ptr_reg] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Control state, pointers, head/skid occupancy, count and sticky error.
  always_ff @(posedge clk_320M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      head_reg      <= '0;
      head_vld_reg  <= 1'b0;
      skid_vld_reg  <= 1'b0;
      count_reg     <= '0;
      err_reg       <= 1'b0;
      init_done_reg <= 1'b0;
    end else if (clr) begin
      state_reg     <= ST_INIT;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      head_reg      <= '0;
      head_vld_reg  <= 1'b0;
      skid_vld_reg  <= 1'b0;
      count_reg     <= '0;
      err_reg       <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        skid_vld_reg <= 1'b1;
      end else if (skid_take) begin
        skid_vld_reg <= 1'b0;
      end
      if (bypass) begin
        head_reg     <= i_free_addr;
        head_vld_reg <= 1'b1;
      end else if (skid_take) begin
        head_reg     <= rd_data_reg;
        head_vld_reg <= 1'b1;
      end else if (pop) begin
        head_vld_reg <= 1'b0;
      end
      if (init_wr) begin
        count_reg <= count_reg + 1'b1;
      end else begin
        count_reg <= count_reg + CWIDTH'(free_acc) - CWIDTH'(pop);
      end
      err_reg       <= err_reg || free_drop;
      init_done_reg <= init_done_reg || (state_reg == ST_READY);
    end
  end

  assign o_alloc_valid  = head_vld_reg;
  assign o_alloc_addr   = head_reg;
  assign o_init_done    = init_done_reg;
  assign o_free_count   = count_reg;
  assign o_err_overflow = err_reg;

endmodule
